// File: rtl/pic_isa_pkg.sv
// pic_isa_pkg: instruction classes, op codes, field encodings and encoder FSM states
package pic_isa_pkg;
  localparam logic [1:0] BYTE = 2'b00;
  localparam logic [1:0] BIT  = 2'b01;
  localparam logic [1:0] LIT  = 2'b11;
  localparam logic [3:0] OP_MOV  = 4'd0;
  localparam logic [3:0] OP_MOVWF = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_INC  = 4'd5;
  localparam logic [3:0] OP_DEC  = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_CLR  = 4'd9;
  localparam logic [3:0] OP_IOR  = 4'd10;
  localparam logic [3:0] OP_SWAP = 4'd11;
  localparam logic [3:0] OP_COM  = 4'd12;
  localparam logic [3:0] OP_BSF  = 4'd13;
  localparam logic [3:0] OP_BCF  = 4'd14;
  typedef enum logic [1:0] {IDLE, OPC, OPR} state_t;
  // Returns {supported, field}; unsupported codes fall back to field 0000
  function automatic logic [4:0] byte_field(input logic [3:0] c);
    case (c)
      OP_MOV:   return 5'b1_1000;
      OP_MOVWF: return 5'b1_0000;
      OP_ADD:   return 5'b1_0111;
      OP_SUB:   return 5'b1_0010;
      OP_AND:   return 5'b1_0101;
      OP_INC:   return 5'b1_1010;
      OP_DEC:   return 5'b1_0011;
      OP_XOR:   return 5'b1_0110;
      OP_CLR:   return 5'b1_0001;
      OP_IOR:   return 5'b1_0100;
      OP_SWAP:  return 5'b1_1110;
      OP_COM:   return 5'b1_1001;
      default:  return 5'b0_0000;
    endcase
  endfunction
  function automatic logic [4:0] lit_field(input logic [3:0] c);
    case (c)
      OP_MOV:  return 5'b1_0000;
      OP_IOR:  return 5'b1_1000;
      OP_AND:  return 5'b1_1001;
      OP_XOR:  return 5'b1_1010;
      OP_SUB:  return 5'b1_1100;
      OP_ADD:  return 5'b1_1110;
      default: return 5'b0_0000;
    endcase
  endfunction
endpackage

// File: rtl/inst_field_map.sv
// inst_field_map: maps a decoded operation to its opcode byte and a supported flag
module inst_field_map
  import pic_isa_pkg::*;
(
  input  logic [3:0] i_code,
  input  logic       i_lit,
  input  logic       i_d,
  input  logic [2:0] i_bit,
  output logic [7:0] o_opc,
  output logic       o_sup
);
  logic [4:0] w_bf, w_lf;
  logic       w_bitop;
  always_comb begin
    w_bf    = byte_field(i_code);
    w_lf    = lit_field(i_code);
    w_bitop = !i_lit && (i_code == OP_BSF || i_code == OP_BCF);
    o_opc   = i_lit ? {LIT, w_lf[3:0], 2'b00} :
              w_bitop ? {BIT, 1'b0, i_code == OP_BSF, i_bit, 1'b0} :
              {BYTE, w_bf[3:0], i_d, 1'b0};
    o_sup   = i_lit ? w_lf[4] : (w_bitop || w_bf[4]);
  end
endmodule

// File: rtl/inst_encoder.sv
// inst_encoder: encodes operations into opcode+operand bytes and writes them to program memory
// Define INST_ENCODER_CHECK_EN to reject unsupported ops with an err pulse instead of encoding them as field 0000.
module inst_encoder
  import pic_isa_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prog_clr,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [3:0]        op_code,
  input  logic              op_lit,
  input  logic              op_d,
  input  logic [2:0]        op_bit,
  input  logic [7:0]        op_operand,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              prog_full,
  output logic              err
);
`ifdef INST_ENCODER_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif
  state_t              r_state;
  logic [ADDR_W-1:0]   r_cnt, r_addr;
  logic [7:0]          r_wdata, r_operand;
  logic                r_we, r_full, r_err;
  logic [7:0]          w_opc;
  logic                w_sup;
  inst_field_map u_map (
    .i_code (op_code),
    .i_lit  (op_lit),
    .i_d    (op_d),
    .i_bit  (op_bit),
    .o_opc  (w_opc),
    .o_sup  (w_sup)
  );
  assign op_ready  = (r_state == IDLE) && !r_full && !prog_clr;
  // a clear aborts the byte on the port this very cycle
  assign mem_we    = r_we && !prog_clr;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign prog_full = r_full;
  assign err       = r_err;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_operand <= '0;
      r_we      <= 1'b0;
      r_full    <= 1'b0;
      r_err     <= 1'b0;
    end else if (prog_clr) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_full  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        IDLE: if (op_valid && !r_full) begin
          r_operand <= op_operand;
          if (CHECK_EN && !w_sup) r_err <= 1'b1;
          else begin
            r_we    <= 1'b1;
            r_wdata <= w_opc;
            r_addr  <= r_cnt;
            r_cnt   <= r_cnt + 1'b1;
            r_state <= OPC;
          end
        end
        OPC: begin
          r_wdata <= r_operand;
          r_addr  <= r_cnt;
          r_cnt   <= r_cnt + 1'b1;
          r_state <= OPR;
        end
        OPR: begin
          r_we    <= 1'b0;
          r_full  <= r_addr == ADDR_W'(DEPTH - 1);
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
